// File: rtl/mult_dispatch_pkg.sv
// Shared types and defaults for the multiplier job dispatcher.
// The state encoding, default geometry and the pointer-width helper live here.
package mult_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 64;

    // Bits needed to index 'depth' entries (ceil(log2(depth)), minimum 1).
    function automatic int log2_depth(input int depth);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_job_fifo.sv
// Small synchronous job FIFO holding packed operand pairs.
// A push is refused while full even if a pop happens in the same cycle.
module mult_job_fifo
    import mult_dispatch_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [log2_depth(DEPTH):0] count
);

    localparam int AW = log2_depth(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally; count separates full from empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_job_dispatcher.sv
// Job front-end for sequential_multiplier: queues operand pairs, issues them one at a time,
// returns products in order. Define MULT_DISPATCH_TIMEOUT_EN to bound the WAIT state.
//
// state | meaning
// IDLE  | nothing in flight; load and pop the FIFO head when one is queued
// ISSUE | mul_start high for this single cycle, wait counter cleared
// WAIT  | multiplier busy; done ignored on the first cycle to mask a stale level
// HOLD  | result presented on out_valid until out_ready
module mult_job_dispatcher
    import mult_dispatch_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_error,
    output logic               busy
);

    localparam int CW = log2_depth(FIFO_DEPTH) + 1;

    state_t             state;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [2*WIDTH-1:0] fifo_head;
    logic               load_next;
    logic               wait_first;

    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign load_next = !fifo_empty && ((state == IDLE) || ((state == HOLD) && out_ready));

    mult_job_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && in_ready),
        .wdata ({in_a, in_b}),
        .pop   (load_next),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef MULT_DISPATCH_TIMEOUT_EN
    localparam int TW = log2_depth(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          err_q;
    logic          timed_out;

    // True on the WAIT cycle in which the counter reaches TIMEOUT.
    assign timed_out = (wait_cnt == TW'(TIMEOUT - 1));
    assign out_error = err_q;
`else
    assign out_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            wait_first  <= 1'b0;
`ifdef MULT_DISPATCH_TIMEOUT_EN
            wait_cnt    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_next) begin
                        {mul_a, mul_b} <= fifo_head;
                        mul_start      <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_first <= 1'b1;
`ifdef MULT_DISPATCH_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    wait_first <= 1'b0;
`ifdef MULT_DISPATCH_TIMEOUT_EN
                    if (wait_cnt != TW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                    // A done seen on the timeout cycle still wins.
                    if (!wait_first && mul_done) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
`ifdef MULT_DISPATCH_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (timed_out) begin
                        out_product <= '0;
                        err_q       <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (load_next) begin
                            {mul_a, mul_b} <= fifo_head;
                            mul_start      <= 1'b1;
                            state          <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_dispatcher.sv
// Self-checking bench for mult_job_dispatcher: stub multiplier, queue-based reference model,
// directed cases plus a randomized phase. Timeout cases run when MULT_DISPATCH_TIMEOUT_EN is defined.
module tb_mult_job_dispatcher;

    localparam int W  = 8;
    localparam int TO = 64;
`ifdef MULT_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [2*W-1:0] mul_product = '0;
    logic          mul_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic          out_error;
    logic          busy;

    mult_job_dispatcher #(.WIDTH(W), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .out_error(out_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed { logic [7:0] a; logic [7:0] b; } job_t;

    // Reference model: accepted-but-unissued jobs, the single in-flight result, and returned results.
    job_t in_q[$];
    int   got[$];
    bit   inflight = 0, hold_seen = 0, start_due = 0;
    int   exp_prod = 0, exp_cyc = 0;
    bit   exp_err = 0;
    int   acc_cnt = 0, got_cnt = 0, n_starts = 0;
    int   lat_force = 0;
    int   stub_rem = 0, stub_pend = 0;
    bit   stub_first = 0;

    always @(negedge clk) begin : model_proc
        int   lat;
        job_t j;
        if (reset) begin
            chk("start_timing", mul_start, start_due);
            if (mul_start) begin
                n_starts++;
                chk("start_while_inflight", inflight, 0);
                chk("start_has_job", in_q.size() > 0, 1);
                if (in_q.size() > 0) begin
                    j = in_q.pop_front();
                    chk("issue_a", mul_a, j.a);
                    chk("issue_b", mul_b, j.b);
                    lat = (lat_force != 0) ? lat_force : int'($urandom_range(2, 6));
                    if (TO_EN && lat > TO) begin
                        exp_prod = 0; exp_err = 1; exp_cyc = cyc + TO + 1;
                    end else begin
                        exp_prod = int'(j.a) * int'(j.b); exp_err = 0; exp_cyc = cyc + lat + 1;
                    end
                    inflight = 1; hold_seen = 0;
                    stub_rem = lat; stub_first = 1;
                    stub_pend = int'(mul_a) * int'(mul_b);
                end
            end else if (stub_rem > 0) begin
                // Stub keeps the previous done level through the first WAIT cycle.
                if (!stub_first) mul_done = 1'b0;
                stub_first = 0;
                stub_rem--;
                if (stub_rem == 0) begin
                    mul_done = 1'b1;
                    mul_product = 16'(stub_pend);
                end
            end
            chk("in_ready", in_ready, in_q.size() < 4);
            chk("busy", busy, (in_q.size() > 0) || inflight);
            if (inflight && !out_valid && cyc == exp_cyc) chk("result_on_time", out_valid, 1);
            if (out_valid) begin
                if (!inflight) begin
                    chk("valid_without_job", out_valid, 0);
                end else begin
                    if (!hold_seen) chk("result_latency", cyc, exp_cyc);
                    hold_seen = 1;
                    chk("out_product", out_product, exp_prod);
                    chk("out_error", out_error, exp_err);
                    if (out_ready) begin
                        got.push_back(int'(out_product));
                        got_cnt++;
                        inflight = 0; hold_seen = 0;
                    end
                end
            end
            start_due = (in_q.size() > 0) && !inflight;
            if (in_valid && in_ready) begin
                j.a = in_a; j.b = in_b;
                in_q.push_back(j);
                acc_cnt++;
            end
        end else begin
            in_q.delete();
            inflight = 0; hold_seen = 0; start_due = 0;
            stub_rem = 0; acc_cnt = 0; got_cnt = 0;
        end
    end

    task automatic push_job(input int a, input int b, output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; acc_cyc = cyc; break; end
        end
        chk("push_accepted", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int c);
        bit seen;
        seen = 0; c = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mul_start) begin seen = 1; c = cyc; break; end
        end
        chk("start_seen", seen, 1);
    endtask

    task automatic wait_valid(output int c);
        bit seen;
        seen = 0; c = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; c = cyc; break; end
        end
        chk("valid_seen", seen, 1);
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (got.size() >= n) break;
        end
        chk("results_count", got.size(), n);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tn, ts, tv, g0, s0;
        int exp5 [6];
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);

        // Single job 15 x 10.
        out_ready = 1'b1; lat_force = 3; s0 = n_starts;
        push_job(15, 10, tn);
        wait_start(ts);
        chk("t1_start_latency", ts - tn, 2);
        chk("t1_mul_a", mul_a, 15);
        chk("t1_mul_b", mul_b, 10);
        wait_valid(tv);
        chk("t1_done_latency", tv - ts, 4);
        chk("t1_product", out_product, 150);
        chk("t1_error", out_error, 0);
        repeat (5) @(negedge clk);
        chk("t1_one_start", n_starts - s0, 1);

        // Five jobs with the consumer stalled, then backpressure and push-while-full.
        @(posedge clk); #1;
        out_ready = 1'b0; lat_force = 0; g0 = got.size();
        push_job(255, 255, tn);
        push_job(0, 77, tn);
        push_job(1, 200, tn);
        push_job(12, 12, tn);
        push_job(3, 5, tn);
        @(negedge clk);
        chk("t2_full_in_ready", in_ready, 0);
        wait_valid(tv);
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_hold_stable", out_product, 65025);
        end
        chk("t2_no_start_in_hold", n_starts - s0, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9; out_ready = 1'b1;
        @(negedge clk);
        chk("t2_push_refused_when_full", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_push_accepted_after_pop", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_got(g0 + 6);
        exp5 = '{65025, 0, 200, 144, 15, 63};
        for (int i = 0; i < 6; i++) begin
            if (got.size() > g0 + i) chk("t2_order", got[g0 + i], exp5[i]);
        end

        // Reset while a job waits and three more are queued.
        @(posedge clk); #1;
        out_ready = 1'b0; lat_force = 30;
        push_job(2, 3, tn);
        push_job(4, 5, tn);
        push_job(6, 7, tn);
        push_job(8, 9, tn);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        g0 = got.size();
        @(negedge clk);
        chk("t3_in_ready", in_ready, 1);
        chk("t3_out_valid", out_valid, 0);
        chk("t3_mul_start", mul_start, 0);
        chk("t3_busy", busy, 0);
        @(posedge clk); #1;
        lat_force = 0; out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("t3_no_stale_result", got.size(), g0);

`ifdef MULT_DISPATCH_TIMEOUT_EN
        // Stalled multiplier, then done exactly at and one past the timeout boundary.
        lat_force = 1000;
        push_job(3, 4, tn);
        wait_start(ts);
        wait_valid(tv);
        chk("to_latency", tv - ts, 65);
        chk("to_error", out_error, 1);
        chk("to_product", out_product, 0);
        lat_force = 64;
        push_job(5, 6, tn);
        wait_start(ts);
        wait_valid(tv);
        chk("to_edge_latency", tv - ts, 65);
        chk("to_edge_error", out_error, 0);
        chk("to_edge_product", out_product, 30);
        lat_force = 65;
        push_job(7, 8, tn);
        wait_start(ts);
        wait_valid(tv);
        chk("to_late_error", out_error, 1);
        chk("to_late_product", out_product, 0);
        lat_force = 0;
        push_job(9, 9, tn);
        wait_start(ts);
        wait_valid(tv);
        chk("to_next_error", out_error, 0);
        chk("to_next_product", out_product, 81);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       in_a = 8'd0;
                1:       in_a = 8'd255;
                default: in_a = 8'($urandom_range(0, 255));
            endcase
            in_b      = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) break;
        end
        chk("drain_busy", busy, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("jobs_returned", got_cnt, acc_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_job_dispatcher.md
# mult_job_dispatcher

Job front-end for `sequential_multiplier`. Operand pairs arrive on a valid/ready stream and are buffered in a small FIFO. The block issues each pair to the multiplier as a one-cycle `start` pulse, waits for `done`, and returns the product on a valid/ready output stream in issue order. It wraps the multiplier on both sides: it feeds A/B/start and consumes product/done.

## Interface
- `WIDTH`, 8: operand width; product width is 2*WIDTH.
- `FIFO_DEPTH`, 4: job FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT`, 64: maximum cycles spent in WAIT (used only with the timeout feature).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low (0 = reset). The multiplier's active-high reset is driven from `~reset` at top level.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_a`, `in_b`  in  WIDTH each  operands.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`  out  WIDTH each  registered operands; stable from ISSUE through the end of WAIT.
- `mul_product`  in  2*WIDTH  multiplier result.
- `mul_done`  in  1  multiplier completion, sampled as a level.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_product`  out  2*WIDTH  captured product.
- `out_error`  out  1  result is a timeout, not a real product.
- `busy`  out  1  state ≠ IDLE, or FIFO not empty.

## Operation
- Reset (while `reset`=0 at a clock edge): FIFO emptied; state IDLE; `mul_start`, `out_valid`, `out_error` = 0; `mul_a`, `mul_b`, `out_product` = 0; wait counter = 0. Reset has priority over everything, including mid-WAIT and mid-HOLD. Queued and in-flight jobs are discarded.
- FIFO push: occurs on `in_valid && in_ready`. There is no push while full, even if a pop happens in the same cycle. Pop occurs on the IDLE→ISSUE or HOLD→ISSUE transition. Pointers wrap modulo FIFO_DEPTH; count is tracked separately to distinguish full from empty.
- States:
  - IDLE: if the FIFO is non-empty, load `mul_a`/`mul_b` from the head, pop, and go to ISSUE.
  - ISSUE: `mul_start`=1 for exactly this cycle; clear the wait counter; go to WAIT.
  - WAIT: `mul_done` is ignored in the first WAIT cycle (masks stale done). From the second WAIT cycle on, the first sampled `mul_done`=1 captures `mul_product` into `out_product`, sets `out_error`=0, and goes to HOLD. The counter increments each WAIT cycle.
  - HOLD: `out_valid`=1 with `out_product`/`out_error` held stable. On `out_ready`: if the FIFO is non-empty, load and pop the next job and go to ISSUE; otherwise go to IDLE.
- Results are returned strictly in input order; only one job is in flight.
- Arithmetic: none internal; the product is passed through unmodified at 2*WIDTH bits.

## Timing
- Input accepted at cycle N → FIFO non-empty at N+1 → ISSUE (`mul_start`=1) at N+2 when IDLE.
- `mul_done` first seen at cycle D → `out_valid`=1 at D+1.
- Back-to-back: `out_ready` in HOLD at cycle H → next `mul_start` at H+1.
- `out_valid` drops the cycle after the handshake.
- `in_ready` is combinational from registered count only; there is no in→out combinational path.

## Configuration
- `MULT_DISPATCH_TIMEOUT_EN` defined:
  - The WAIT counter saturates at TIMEOUT. Reaching TIMEOUT without done → `out_product`=0, `out_error`=1, go to HOLD. The block then continues with the next job.
  - A `mul_done` arriving in the same cycle the counter reaches TIMEOUT wins; the result is a normal product.
- Macro undefined: no counter logic; WAIT waits indefinitely; `out_error` is tied 0.

## Structure
- Package `mult_dispatch_pkg`: state enum (IDLE, ISSUE, WAIT, HOLD), default WIDTH/FIFO_DEPTH/TIMEOUT localparams, and the log2-depth helper.
- Sub-module `mult_job_fifo`: 2*WIDTH-wide synchronous FIFO with push/pop/full/empty/count and the same active-low synchronous reset.
- The FSM, wait counter and output register live in `mult_job_dispatcher`.

## Test plan
- Single job 15×10, `out_ready`=1 → exactly one `mul_start` pulse with `mul_a`=15, `mul_b`=10; `out_product`=16'd150, `out_error`=0.
- Five back-to-back jobs (255×255, 0×77, 1×200, 12×12, 3×5) with `out_ready` held 0 → `in_ready` low only when 4 entries are stored. After `out_ready`=1, results arrive in order: 65025, 0, 200, 144, 15.
- Backpressure: `out_ready`=0 for 20 cycles in HOLD → `out_product` stable, `mul_start` stays 0, and the FIFO keeps accepting until full.
- Timeout (macro defined), stub multiplier with `mul_done`=0 → `out_valid`=1 and `out_error`=1 with `out_product`=0 on the cycle after 64 WAIT cycles. The following job completes normally.
- `reset`=0 mid-WAIT with 3 jobs queued → next cycle: `in_ready`=1, `out_valid`=0, `mul_start`=0, `busy`=0. After release, no stale result is produced.
- Push into a full FIFO while HOLD pops (`out_ready`=1) → push refused that cycle and accepted the next cycle; no job is lost or duplicated.
